// File: rtl/mem_port_master.sv
// mem_port_master: initiator for a single-port synchronous block memory.
// Takes load/store requests on a valid/ready handshake, drives the memory
// port from registers, follows each load through the read pipeline and
// returns the read data in request order from a response FIFO.
// Ports:
//   clka, rsta_n                   clock, async active-low reset
//   req_valid/req_ready/req_we     request handshake, 1 = store
//   req_addr, req_wdata            word address, store data
//   rsp_valid/rsp_ready/rsp_rdata  read response handshake, FIFO head
//   mem_wea/mem_addra/mem_dina     registered memory port controls
//   mem_douta                      memory read data
//   busy                           reads in flight or responses buffered
module mem_port_master #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RSP_DEPTH    = 4
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [DATA_W-1:0] mem_dina,
  input  logic [DATA_W-1:0] mem_douta,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                    mem_wea_q, mem_wea_d;
  logic [ADDR_W-1:0]       mem_addra_q, mem_addra_d;
  logic [DATA_W-1:0]       mem_dina_q, mem_dina_d;
  logic                    busy_q, busy_d;
  logic [READ_LATENCY:0]   tag_q, tag_d;
  logic [CNT_W-1:0]        credit_q, credit_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]       fifo_q [RSP_DEPTH];
  logic [DATA_W-1:0]       fifo_d [RSP_DEPTH];

  logic accept_c, load_acc_c, push_c, pop_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state logic for the port, read pipeline, credit counter and FIFO.
  always_comb begin
    accept_c   = req_valid && req_ready_q;
    load_acc_c = accept_c && !req_we;
    // The oldest tag bit marks the edge at which mem_douta holds load data.
    push_c     = tag_q[READ_LATENCY];
    pop_c      = rsp_valid_q && rsp_ready;

    tag_d       = {tag_q[READ_LATENCY-1:0], load_acc_c};
    mem_wea_d   = accept_c && req_we;
    mem_addra_d = accept_c ? req_addr  : mem_addra_q;
    mem_dina_d  = accept_c ? req_wdata : mem_dina_q;

    // A push only moves an entry from in-flight to buffered: credit unchanged.
    credit_d = credit_q + CNT_W'(load_acc_c) - CNT_W'(pop_c);
    count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    wr_ptr_d = push_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_c  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    fifo_d = fifo_q;
    if (push_c) fifo_d[wr_ptr_q] = mem_douta;

    // Head is taken from the updated array so a push into an emptying FIFO
    // becomes the head straight away.
    rsp_rdata_d = (count_d != '0) ? fifo_d[rd_ptr_d] : rsp_rdata_q;
    rsp_valid_d = (count_d != '0);
    busy_d      = (credit_d != '0);
    req_ready_d = (credit_d < CNT_W'(RSP_DEPTH));
  end

  // Control and output registers.
  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_wea_q   <= 1'b0;
      mem_addra_q <= '0;
      mem_dina_q  <= '0;
      busy_q      <= 1'b0;
      tag_q       <= '0;
      credit_q    <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_wea_q   <= mem_wea_d;
      mem_addra_q <= mem_addra_d;
      mem_dina_q  <= mem_dina_d;
      busy_q      <= busy_d;
      tag_q       <= tag_d;
      credit_q    <= credit_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clka) begin
    fifo_q <= fifo_d;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_wea   = mem_wea_q;
  assign mem_addra = mem_addra_q;
  assign mem_dina  = mem_dina_q;
  assign busy      = busy_q;

endmodule
